// File: rtl/free_memory_if.sv
// Card-side request/status signals and the RAM port of the block deallocator.
interface free_memory_if;
  logic        enable;
  logic [9:0]  free_address;
  logic        busy;
  logic        addr_freed;
  logic        error;
  logic [1:0]  error_code;
  logic [5:0]  blocks_freed;
  logic [9:0]  ram_address;
  logic        ram_clock;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;

  modport slave (
    input  enable, free_address, ram_q,
    output busy, addr_freed, error, error_code, blocks_freed,
           ram_address, ram_clock, ram_data, ram_wren
  );

  modport master (
    output enable, free_address, ram_q,
    input  busy, addr_freed, error, error_code, blocks_freed,
           ram_address, ram_clock, ram_data, ram_wren
  );
endinterface

// File: rtl/free_memory.sv
// Block deallocator: walks a chain of allocated 32-word blocks from a head
// address and clears each header word, reporting count and abort reason.
module free_memory #(
  parameter int BLOCK_WORDS  = 32,
  parameter int MAX_BLOCKS   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic         clock,
  input  logic         reset,
  free_memory_if.slave bus
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(READ_LATENCY - 1);
  localparam logic [5:0]        MAX_CNT   = 6'(MAX_BLOCKS);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK_ADDR, S_READ, S_WAIT, S_EVAL, S_WRITE, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_ADDR, ERR_DOUBLE, ERR_OVERRUN
  } err_e;

  function automatic logic addr_bad(input logic [9:0] a);
    return (a == '0) || (a[OFF_W-1:0] != '0);
  endfunction

  state_e              state_q, state_d;
  err_e                code_q, code_d, finish_code;
  logic [9:0]          cur_addr_q, cur_addr_d;
  logic [9:0]          next_addr_q, next_addr_d;
  logic [5:0]          count_q, count_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                busy_q, busy_d;
  logic                freed_q, freed_d;
  logic                wren_q, wren_d;
  logic                finish;
  logic                ram_q_unused;

  // The next-pointer checks are folded into WRITE so each block costs
  // READ + WAIT + EVAL + WRITE cycles; CHECK_ADDR only vets the head.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    code_d      = code_q;
    cur_addr_d  = cur_addr_q;
    next_addr_d = next_addr_q;
    count_d     = count_q;
    wait_d      = wait_q;
    busy_d      = busy_q;
    freed_d     = 1'b0;
    wren_d      = 1'b0;
    finish      = 1'b0;
    finish_code = ERR_NONE;

    unique case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          cur_addr_d = bus.free_address;
          count_d    = '0;
          code_d     = ERR_NONE;
          busy_d     = 1'b1;
          state_d    = S_CHECK_ADDR;
        end
      end
      S_CHECK_ADDR: begin
        if (addr_bad(cur_addr_q)) begin
          finish      = 1'b1;
          finish_code = ERR_ADDR;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        wait_d  = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_EVAL;
        else              wait_d  = wait_q - 1'b1;
      end
      S_EVAL: begin
        if (!bus.ram_q[31]) begin
          finish      = 1'b1;
          finish_code = ERR_DOUBLE;
        end else begin
          next_addr_d = bus.ram_q[9:0];
          wren_d      = 1'b1;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        count_d = count_q + 6'd1;
        if (next_addr_q == '0) begin
          finish = 1'b1;
        end else if (count_d == MAX_CNT) begin
          finish      = 1'b1;
          finish_code = ERR_OVERRUN;
        end else if (addr_bad(next_addr_q)) begin
          finish      = 1'b1;
          finish_code = ERR_ADDR;
        end else begin
          cur_addr_d = next_addr_q;
          state_d    = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d = S_DONE;
      code_d  = finish_code;
      busy_d  = 1'b0;
      freed_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values present before the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      code_q      <= ERR_NONE;
      cur_addr_q  <= '0;
      next_addr_q <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      freed_q     <= 1'b0;
      wren_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      cur_addr_q  <= cur_addr_d;
      next_addr_q <= next_addr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      freed_q     <= freed_d;
      wren_q      <= wren_d;
    end
  end

  // Header bits between the flag and the pointer carry no meaning here.
  assign ram_q_unused = ^bus.ram_q[30:10];

  assign bus.busy         = busy_q;
  assign bus.addr_freed   = freed_q;
  assign bus.error        = (code_q != ERR_NONE);
  assign bus.error_code   = code_q;
  assign bus.blocks_freed = count_q;
  assign bus.ram_address  = cur_addr_q;
  assign bus.ram_clock    = clock;
  assign bus.ram_data     = '0;
  assign bus.ram_wren     = wren_q;

endmodule

// File: tb/tb_free_memory.sv
// Directed bench for free_memory: synchronous RAM model with a write log,
// hand-computed latencies, write sequences and status codes.
module tb_free_memory;

  logic clk = 1'b0;
  logic rst;

  free_memory_if bus ();

  free_memory #(
    .BLOCK_WORDS (32),
    .MAX_BLOCKS  (4),
    .READ_LATENCY(1)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  int          wr_addrs [64];
  int          wr_count = 0;
  int          data_bad = 0;
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic        rearm = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // One-port synchronous RAM; optional re-arm keeps the self-loop header allocated.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.ram_wren) begin
      mem[bus.ram_address] <= (rearm && bus.ram_address == 10'd32) ? 32'h8000_0020 : bus.ram_data;
      if (wr_count < 64) wr_addrs[wr_count] <= int'(bus.ram_address);
      wr_count <= wr_count + 1;
      if (bus.ram_data != 32'h0) data_bad <= data_bad + 1;
    end
    bus.ram_q <= mem[bus.ram_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Cycle 0 is the cycle enable is sampled; lat is the cycle addr_freed is seen.
  task automatic run_op(input logic [9:0] a, output int lat);
    lat = -1;
    @(negedge clk);
    bus.enable       = 1'b1;
    bus.free_address = a;
    @(posedge clk);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.enable = 1'b0;
        check("busy_rise", bus.busy, 1'b1);
      end
      if (bus.addr_freed) begin
        lat = cyc;
        break;
      end
    end
    check("done_seen", (lat > 0), 1'b1);
    if (lat > 0) begin
      @(negedge clk);
      check("pulse_width", bus.addr_freed, 1'b0);
      check("busy_after", bus.busy, 1'b0);
    end
  endtask

  initial begin
    int lat;
    int base;

    rst              = 1'b1;
    bus.enable       = 1'b0;
    bus.free_address = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   bus.busy,         1'b0);
    check("rst_freed",  bus.addr_freed,   1'b0);
    check("rst_error",  bus.error,        1'b0);
    check("rst_code",   bus.error_code,   2'd0);
    check("rst_blocks", bus.blocks_freed, 6'd0);
    check("rst_addr",   bus.ram_address,  10'd0);
    check("rst_wren",   bus.ram_wren,     1'b0);
    rst = 1'b0;

    // Single block
    poke(10'd64, 32'h8000_0000);
    base = wr_count;
    run_op(10'd64, lat);
    check("single_lat",    lat, 6);
    check("single_error",  bus.error, 1'b0);
    check("single_code",   bus.error_code, 2'd0);
    check("single_blocks", bus.blocks_freed, 6'd1);
    check("single_writes", wr_count - base, 1);
    check("single_wr_addr", wr_addrs[base], 64);
    check("single_mem",    mem[64], 32'h0);

    // Three-block chain 32 -> 96 -> 64
    poke(10'd32, 32'h8000_0060);
    poke(10'd96, 32'h8000_0040);
    poke(10'd64, 32'h8000_0000);
    base = wr_count;
    run_op(10'd32, lat);
    check("chain_lat",    lat, 14);
    check("chain_error",  bus.error, 1'b0);
    check("chain_blocks", bus.blocks_freed, 6'd3);
    check("chain_writes", wr_count - base, 3);
    check("chain_wr0",    wr_addrs[base],     32);
    check("chain_wr1",    wr_addrs[base + 1], 96);
    check("chain_wr2",    wr_addrs[base + 2], 64);

    // Double free
    poke(10'd128, 32'h0000_0000);
    base = wr_count;
    run_op(10'd128, lat);
    check("dbl_lat",    lat, 5);
    check("dbl_error",  bus.error, 1'b1);
    check("dbl_code",   bus.error_code, 2'd2);
    check("dbl_blocks", bus.blocks_freed, 6'd0);
    check("dbl_writes", wr_count - base, 0);
    repeat (3) @(negedge clk);
    check("dbl_code_held", bus.error_code, 2'd2);

    // Bad head addresses
    base = wr_count;
    run_op(10'd0, lat);
    check("zero_lat",  lat, 2);
    check("zero_code", bus.error_code, 2'd1);
    check("zero_error", bus.error, 1'b1);
    run_op(10'd33, lat);
    check("mis_lat",   lat, 2);
    check("mis_code",  bus.error_code, 2'd1);
    check("bad_writes", wr_count - base, 0);

    // Self-loop re-armed after every write: stops on the block limit
    rearm = 1'b1;
    poke(10'd32, 32'h8000_0020);
    base = wr_count;
    run_op(10'd32, lat);
    check("loop_lat",    lat, 18);
    check("loop_code",   bus.error_code, 2'd3);
    check("loop_blocks", bus.blocks_freed, 6'd4);
    check("loop_writes", wr_count - base, 4);

    // Self-loop without re-arm: second visit finds it free
    rearm = 1'b0;
    poke(10'd32, 32'h8000_0020);
    base = wr_count;
    run_op(10'd32, lat);
    check("loop1_lat",    lat, 9);
    check("loop1_code",   bus.error_code, 2'd2);
    check("loop1_blocks", bus.blocks_freed, 6'd1);
    check("loop1_writes", wr_count - base, 1);

    // Reset during WRITE of the second chain block
    poke(10'd32, 32'h8000_0060);
    poke(10'd96, 32'h8000_0040);
    poke(10'd64, 32'h8000_0000);
    base = wr_count;
    @(negedge clk);
    bus.enable       = 1'b1;
    bus.free_address = 10'd32;
    @(posedge clk);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.enable = 1'b0;
    end
    check("mid_wren",  bus.ram_wren, 1'b1);
    check("mid_addr",  bus.ram_address, 10'd96);
    rst = 1'b1;
    #1;
    check("mid_rst_wren",   bus.ram_wren, 1'b0);
    check("mid_rst_busy",   bus.busy, 1'b0);
    check("mid_rst_blocks", bus.blocks_freed, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_writes", wr_count - base, 1);
    check("mid_mem96",  mem[96], 32'h8000_0040);

    base = wr_count;
    run_op(10'd96, lat);
    check("resume_lat",    lat, 10);
    check("resume_error",  bus.error, 1'b0);
    check("resume_blocks", bus.blocks_freed, 6'd2);
    check("resume_writes", wr_count - base, 2);
    check("resume_wr0",    wr_addrs[base],     96);
    check("resume_wr1",    wr_addrs[base + 1], 64);

    check("write_data_zero", data_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
